sift_extrema_detect: RTL and testbench

Parametrised, pipelined successor to the single-compare big-value flag in SIFT_Detection. It tests one DoG centre sample against a full neighbour set, normally 26 neighbours from the 3x3x3 scale-space cube. It flags local maxima and minima, gated by strict/non-strict mode and contrast thresholds, with a fixed 2-cycle valid pipeline. It also keeps a per-frame extrema count, reported at end of frame, for keypoint budgeting downstream.

---
 rtl/sift_ext_pkg.sv | 25 ++
 rtl/sift_nb_cmp.sv | 44 ++++
 rtl/sift_extrema_detect.sv | 109 ++++++++++
 tb/tb_sift_extrema_detect.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sift_ext_pkg.sv
// Shared defaults, neighbour packing indices and pipeline control types for SIFT extrema detection.
// No logic of its own; imported by the compare bank and the detector top.
package sift_ext_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int NUM_NB_DEF = 26;
    localparam int CNT_W_DEF  = 16;

    // 3x3x3 cube packing: lower scale, same scale without the centre, upper scale
    localparam int NB_LO_FIRST  = 0;
    localparam int NB_LO_LAST   = 8;
    localparam int NB_MID_FIRST = 9;
    localparam int NB_MID_LAST  = 16;
    localparam int NB_UP_FIRST  = 17;
    localparam int NB_UP_LAST   = 25;

    typedef struct packed {
        logic valid;
        logic sof;
        logic eof;
        logic hiOk;
        logic loOk;
    } stageCtl_t;

endpackage

// File: rtl/sift_nb_cmp.sv
// Stage-1 compare bank: centre against every neighbour, strict or non-strict, unsigned.
// Latency 1 cycle, registered every clock; no backpressure.
// Strict mode is sampled together with the data it applies to.
module sift_nb_cmp #(
    parameter int DATA_W = 8,
    parameter int NUM_NB = 26
) (
    input  logic                     iclk,
    input  logic                     irst_n,
    input  logic [DATA_W-1:0]        iCenter,
    input  logic [NUM_NB*DATA_W-1:0] iNeighbors,
    input  logic                     iStrict,
    output logic [NUM_NB-1:0]        oGe,
    output logic [NUM_NB-1:0]        oLe
);

    logic [NUM_NB-1:0] geNext;
    logic [NUM_NB-1:0] leNext;

    always_comb begin
        geNext = '0;
        leNext = '0;
        for (int k = 0; k < NUM_NB; k++) begin
            if (iStrict) begin
                geNext[k] = iCenter >  iNeighbors[k*DATA_W +: DATA_W];
                leNext[k] = iCenter <  iNeighbors[k*DATA_W +: DATA_W];
            end else begin
                geNext[k] = iCenter >= iNeighbors[k*DATA_W +: DATA_W];
                leNext[k] = iCenter <= iNeighbors[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            oGe <= '0;
            oLe <= '0;
        end else begin
            oGe <= geNext;
            oLe <= leNext;
        end
    end

endmodule

// File: rtl/sift_extrema_detect.sv
// DoG local max/min detector with contrast thresholds and per-frame extrema count (optional SIFT_EXTREMA_FLAT_SUPPRESS_EN).
// Latency 2 cycles, one sample per cycle.
// No backpressure: every valid sample is accepted.
module sift_extrema_detect
    import sift_ext_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NUM_NB = NUM_NB_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                     iclk,
    input  logic                     irst_n,
    input  logic                     iValid,
    input  logic                     iSof,
    input  logic                     iEof,
    input  logic [DATA_W-1:0]        iCenter,
    input  logic [NUM_NB*DATA_W-1:0] iNeighbors,
    input  logic [DATA_W-1:0]        iThr_hi,
    input  logic [DATA_W-1:0]        iThr_lo,
    input  logic                     iStrict,
    output logic                     oValid,
    output logic                     oMax_en,
    output logic                     oMin_en,
    output logic [CNT_W-1:0]         oExt_cnt,
    output logic                     oCnt_valid
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_NB-1:0] ge1;
    logic [NUM_NB-1:0] le1;
    stageCtl_t         ctl1;
    logic [CNT_W-1:0]  runCnt;

    logic              maxRaw;
    logic              minRaw;
    logic              maxSel;
    logic              minSel;
    logic              isExt;
    logic [CNT_W-1:0]  baseCnt;
    logic [CNT_W-1:0]  nextCnt;

    sift_nb_cmp #(
        .DATA_W (DATA_W),
        .NUM_NB (NUM_NB)
    ) uNbCmp (
        .iclk       (iclk),
        .irst_n     (irst_n),
        .iCenter    (iCenter),
        .iNeighbors (iNeighbors),
        .iStrict    (iStrict),
        .oGe        (ge1),
        .oLe        (le1)
    );

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            ctl1 <= '0;
        end else begin
            ctl1.valid <= iValid;
            ctl1.sof   <= iValid & iSof;
            ctl1.eof   <= iValid & iEof;
            ctl1.hiOk  <= iCenter >= iThr_hi;
            ctl1.loOk  <= iCenter <= iThr_lo;
        end
    end

    always_comb begin
        maxRaw = ctl1.valid & (&ge1) & ctl1.hiOk;
        minRaw = ctl1.valid & (&le1) & ctl1.loOk;
`ifdef SIFT_EXTREMA_FLAT_SUPPRESS_EN
        // A flat neighbourhood is neither a max nor a min and is not counted
        maxSel = maxRaw & ~minRaw;
        minSel = minRaw & ~maxRaw;
`else
        maxSel = maxRaw;
        minSel = minRaw;
`endif
        isExt   = maxSel | minSel;
        baseCnt = ctl1.sof ? '0 : runCnt;
        nextCnt = baseCnt;
        if (isExt && (baseCnt != CNT_MAX)) begin
            nextCnt = baseCnt + CNT_W'(1);
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            oValid     <= 1'b0;
            oMax_en    <= 1'b0;
            oMin_en    <= 1'b0;
            oCnt_valid <= 1'b0;
            oExt_cnt   <= '0;
            runCnt     <= '0;
        end else begin
            oValid     <= ctl1.valid;
            oMax_en    <= maxSel;
            oMin_en    <= minSel;
            oCnt_valid <= ctl1.valid & ctl1.eof;
            if (ctl1.valid) begin
                runCnt <= nextCnt;
            end
            if (ctl1.valid && ctl1.eof) begin
                oExt_cnt <= nextCnt;
            end
        end
    end

endmodule

// File: tb/tb_sift_extrema_detect.sv
// Bench for sift_extrema_detect: behavioural model compared every cycle plus directed literal checks.
// Two instances share stimulus: default counter width and a 4-bit counter for saturation.
module tb_sift_extrema_detect;

    localparam int DW = 8;
    localparam int NB = 26;

    logic              iclk = 1'b0;
    logic              irst_n = 1'b0;
    logic              iValid = 1'b0;
    logic              iSof = 1'b0;
    logic              iEof = 1'b0;
    logic              iStrict = 1'b0;
    logic [DW-1:0]     iCenter = '0;
    logic [DW-1:0]     iThr_hi = '0;
    logic [DW-1:0]     iThr_lo = '0;
    logic [NB*DW-1:0]  iNeighbors = '0;

    logic              vA, maxA, minA, pulseA;
    logic [15:0]       cntA;
    logic              vB, maxB, minB, pulseB;
    logic [3:0]        cntB;

    int nChecks = 0;
    int nFail   = 0;
    bit chkEn   = 1'b0;

    always #5 iclk = ~iclk;

    sift_extrema_detect #(.DATA_W(DW), .NUM_NB(NB), .CNT_W(16)) dutA (
        .iclk(iclk), .irst_n(irst_n), .iValid(iValid), .iSof(iSof), .iEof(iEof),
        .iCenter(iCenter), .iNeighbors(iNeighbors), .iThr_hi(iThr_hi), .iThr_lo(iThr_lo),
        .iStrict(iStrict), .oValid(vA), .oMax_en(maxA), .oMin_en(minA),
        .oExt_cnt(cntA), .oCnt_valid(pulseA)
    );

    sift_extrema_detect #(.DATA_W(DW), .NUM_NB(NB), .CNT_W(4)) dutB (
        .iclk(iclk), .irst_n(irst_n), .iValid(iValid), .iSof(iSof), .iEof(iEof),
        .iCenter(iCenter), .iNeighbors(iNeighbors), .iThr_hi(iThr_hi), .iThr_lo(iThr_lo),
        .iStrict(iStrict), .oValid(vB), .oMax_en(maxB), .oMin_en(minB),
        .oExt_cnt(cntB), .oCnt_valid(pulseB)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the sample seen at the previous clock edge becomes the visible result at this edge
    bit mV, mSof, mEof, mStrict;
    int mC, mHi, mLo;
    int mNb[NB];
    bit isMax, isMin;
    bit eValid, eMax, eMin, ePulse;
    int eCntA, eCntB, runA, runB;

    always @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            mV = 0; mSof = 0; mEof = 0; mStrict = 0;
            eValid = 0; eMax = 0; eMin = 0; ePulse = 0;
            eCntA = 0; eCntB = 0; runA = 0; runB = 0;
        end else begin
            isMax = mV && (mC >= mHi);
            isMin = mV && (mC <= mLo);
            for (int k = 0; k < NB; k++) begin
                if (mStrict ? (mC <= mNb[k]) : (mC < mNb[k])) isMax = 0;
                if (mStrict ? (mC >= mNb[k]) : (mC > mNb[k])) isMin = 0;
            end
`ifdef SIFT_EXTREMA_FLAT_SUPPRESS_EN
            if (isMax && isMin) begin
                isMax = 0;
                isMin = 0;
            end
`endif
            eValid = mV;
            eMax   = isMax;
            eMin   = isMin;
            ePulse = 0;
            if (mV) begin
                if (mSof) begin
                    runA = 0;
                    runB = 0;
                end
                if (isMax || isMin) begin
                    runA = (runA + 1 > 65535) ? 65535 : runA + 1;
                    runB = (runB + 1 > 15) ? 15 : runB + 1;
                end
                if (mEof) begin
                    eCntA  = runA;
                    eCntB  = runB;
                    ePulse = 1;
                end
            end
            mV = iValid; mSof = iSof; mEof = iEof; mStrict = iStrict;
            mC = int'(iCenter); mHi = int'(iThr_hi); mLo = int'(iThr_lo);
            for (int k = 0; k < NB; k++) mNb[k] = int'(iNeighbors[k*DW +: DW]);
        end
    end

    always @(negedge iclk) begin
        if (chkEn) begin
            chk("model_valid",   {31'd0, vA},     {31'd0, eValid});
            chk("model_max",     {31'd0, maxA},   {31'd0, eMax});
            chk("model_min",     {31'd0, minA},   {31'd0, eMin});
            chk("model_pulse",   {31'd0, pulseA}, {31'd0, ePulse});
            chk("model_cnt",     {16'd0, cntA},   eCntA);
            chk("model_valid_b", {31'd0, vB},     {31'd0, eValid});
            chk("model_max_b",   {31'd0, maxB},   {31'd0, eMax});
            chk("model_min_b",   {31'd0, minB},   {31'd0, eMin});
            chk("model_pulse_b", {31'd0, pulseB}, {31'd0, ePulse});
            chk("model_cnt_b",   {28'd0, cntB},   eCntB);
        end
    end

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic setAll(input int v);
        for (int k = 0; k < NB; k++) iNeighbors[k*DW +: DW] = DW'(v);
    endtask

    task automatic drive(input bit sof, input bit eof, input bit strict, input int c, input int hi, input int lo);
        iValid = 1'b1; iSof = sof; iEof = eof; iStrict = strict;
        iCenter = DW'(c); iThr_hi = DW'(hi); iThr_lo = DW'(lo);
    endtask

    task automatic idle();
        iValid = 1'b0; iSof = 1'b0; iEof = 1'b0;
    endtask

    // Clear local maximum: centre 200 above neighbours 0..175
    task automatic extSample(input bit sof, input bit eof);
        for (int k = 0; k < NB; k++) iNeighbors[k*DW +: DW] = DW'(k * 7);
        drive(sof, eof, 1'b0, 200, 100, 0);
    endtask

    // Centre between neighbours: neither max nor min
    task automatic plainSample(input bit sof, input bit eof);
        for (int k = 0; k < NB; k++) iNeighbors[k*DW +: DW] = (k % 2 == 0) ? DW'(50) : DW'(150);
        drive(sof, eof, 1'b0, 100, 200, 0);
    endtask

    initial begin
        tick();
        chkEn = 1'b1;
        tick();
        irst_n = 1'b1;
        repeat (10) tick();
        chk("idle_valid", {31'd0, vA}, 32'd0);
        chk("idle_cnt", {16'd0, cntA}, 32'd0);

        extSample(1'b0, 1'b0);
        tick(); idle(); tick();
        chk("max_valid", {31'd0, vA}, 32'd1);
        chk("max_hit", {31'd0, maxA}, 32'd1);
        chk("max_not_min", {31'd0, minA}, 32'd0);
        extSample(1'b0, 1'b0);
        iThr_hi = DW'(201);
        tick(); idle(); tick();
        chk("max_below_thr", {31'd0, maxA}, 32'd0);

        setAll(50);
        drive(1'b0, 1'b0, 1'b0, 50, 0, 255);
        tick(); idle(); tick();
`ifdef SIFT_EXTREMA_FLAT_SUPPRESS_EN
        chk("flat_max", {31'd0, maxA}, 32'd0);
        chk("flat_min", {31'd0, minA}, 32'd0);
`else
        chk("flat_max", {31'd0, maxA}, 32'd1);
        chk("flat_min", {31'd0, minA}, 32'd1);
`endif
        drive(1'b0, 1'b0, 1'b1, 50, 0, 255);
        tick(); idle(); tick();
        chk("flat_strict_max", {31'd0, maxA}, 32'd0);
        chk("flat_strict_min", {31'd0, minA}, 32'd0);

        setAll(20);
        iNeighbors[0 +: DW] = DW'(9);
        drive(1'b0, 1'b0, 1'b0, 10, 255, 255);
        tick(); idle(); tick();
        chk("min_one_lower", {31'd0, minA}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 9, 255, 255);
        tick(); idle(); tick();
        chk("min_equal_ok", {31'd0, minA}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            if (i % 3 == 0) extSample(i == 0, i == 7);
            else plainSample(i == 0, i == 7);
            tick();
        end
        idle(); tick();
        chk("frame8_pulse", {31'd0, pulseA}, 32'd1);
        chk("frame8_cnt", {16'd0, cntA}, 32'd3);
        tick();
        chk("frame8_pulse_end", {31'd0, pulseA}, 32'd0);
        chk("frame8_cnt_hold", {16'd0, cntA}, 32'd3);

        plainSample(1'b1, 1'b1);
        tick(); idle(); tick();
        chk("single_pulse", {31'd0, pulseA}, 32'd1);
        chk("single_cnt", {16'd0, cntA}, 32'd0);

        for (int i = 0; i < 22; i++) begin
            if (i < 2) plainSample(i == 0, 1'b0);
            else extSample(1'b0, i == 21);
            tick();
        end
        idle(); tick();
        chk("sat_cnt_wide", {16'd0, cntA}, 32'd20);
        chk("sat_cnt_narrow", {28'd0, cntB}, 32'd15);

        for (int i = 0; i < 5; i++) begin
            extSample(i == 0, 1'b0);
            tick();
        end
        irst_n = 1'b0;
        idle();
        tick(); tick();
        irst_n = 1'b1;
        repeat (5) tick();
        chk("abort_pulse", {31'd0, pulseA}, 32'd0);
        chk("abort_cnt", {16'd0, cntA}, 32'd0);
        chk("abort_cnt_b", {28'd0, cntB}, 32'd0);

        extSample(1'b0, 1'b1);
        tick(); idle(); tick();
        chk("eof_only_pulse", {31'd0, pulseA}, 32'd1);
        chk("eof_only_cnt", {16'd0, cntA}, 32'd1);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
